// File: rtl/gather_packet_injector.sv
// gather_packet_injector
//   Source end of a gather network link. Turns a (stream_id, length) command plus a stream of
//   payload words into one head flit, zero or more body flits and one tail flit. Flits go to a
//   gather router input stage through a single registered output slot. The link sustains one flit
//   per cycle, and valid_o never depends combinationally on ready_i.
//
// Flit format (DW bits):
//   [DW-1:DW-2]                 flit type (FlitHead / FlitBody / FlitTail)
//   head:      [STREAM_ID_H:STREAM_ID_L] = stream id, all other bits zero
//   body/tail: [DW-3:0]                  = payload word
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   cmd_valid/ready      command handshake, with cmd_stream_id and cmd_len (payload words - 1)
//   pld_valid/ready      payload handshake, with pld_data
//   valid_o/data_o       flit output slot to the router
//   ready_i              router can take a flit (~fifo_full)
//   busy                 packet in progress or flit still held in the output slot
module gather_packet_injector #(
  parameter int unsigned LEN_LOG     = 4,
  parameter int unsigned DW          = 32,
  parameter int unsigned STREAM_ID_H = 7,
  parameter int unsigned STREAM_ID_L = 0,
  parameter logic [1:0]  FlitHead    = 2'b10,
  parameter logic [1:0]  FlitBody    = 2'b00,
  parameter logic [1:0]  FlitTail    = 2'b01,
  localparam int unsigned PLD_W      = DW - 2,
  localparam int unsigned SID_W      = STREAM_ID_H - STREAM_ID_L + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  input  logic [SID_W-1:0]   cmd_stream_id,
  input  logic [LEN_LOG-1:0] cmd_len,
  output logic               cmd_ready,
  input  logic               pld_valid,
  input  logic [PLD_W-1:0]   pld_data,
  output logic               pld_ready,
  output logic               valid_o,
  output logic [DW-1:0]      data_o,
  input  logic               ready_i,
  output logic               busy
);

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  state_e             state_q;
  logic [LEN_LOG-1:0] cnt_q;
  logic               valid_q;
  logic [DW-1:0]      data_q;
  // Holds cmd_ready low during reset and for the first cycle after release.
  logic               run_q;

  logic               slot_free;
  logic               cmd_fire;
  logic               pld_fire;
  logic [DW-1:0]      head_flit;

  // The slot can take a new flit when it is empty or its flit leaves this cycle.
  assign slot_free = ~valid_q | ready_i;
  assign cmd_ready = run_q & (state_q == StIdle) & slot_free;
  assign pld_ready = (state_q == StBody) & slot_free;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign pld_fire  = pld_valid & pld_ready;

  always_comb begin
    head_flit                          = '0;
    head_flit[DW-1:DW-2]               = FlitHead;
    head_flit[STREAM_ID_H:STREAM_ID_L] = cmd_stream_id;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      // A departing flit empties the slot unless a new flit reloads it below.
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            cnt_q   <= cmd_len;
            valid_q <= 1'b1;
            data_q  <= head_flit;
            state_q <= StBody;
          end
        end
        StBody: begin
          if (pld_fire) begin
            valid_q <= 1'b1;
            if (cnt_q == '0) begin
              data_q  <= {FlitTail, pld_data};
              state_q <= StIdle;
            end else begin
              data_q <= {FlitBody, pld_data};
              cnt_q  <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign busy    = (state_q != StIdle) | valid_q;

endmodule

// File: tb/tb_gather_packet_injector.sv
module tb_gather_packet_injector;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_stream_id = '0;
  logic [3:0]  cmd_len = '0;
  logic        cmd_ready;
  logic        pld_valid = 1'b0;
  logic [29:0] pld_data = '0;
  logic        pld_ready;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ready_i = 1'b1;
  logic        busy;

  logic [29:0] pld_mem [0:15];
  int          n_checks = 0;
  int          n_pass = 0;

  gather_packet_injector dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_stream_id(cmd_stream_id),
    .cmd_len      (cmd_len),
    .cmd_ready    (cmd_ready),
    .pld_valid    (pld_valid),
    .pld_data     (pld_data),
    .pld_ready    (pld_ready),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Drives one packet and checks every flit that leaves the slot. Inputs change on the falling
  // edge, outputs are sampled 1 time unit later. abort_at >= 0 returns once that many flits left.
  task automatic run_pkt(input logic [7:0] sid, input logic [3:0] len, input bit toggle,
                         input int abort_at);
    int          cyc;
    int          fire_cyc;
    int          flits;
    int          pidx;
    int          want;
    bit          sent;
    bit          stalled;
    logic [31:0] held;
    logic [31:0] exp;
    cyc = 0; fire_cyc = -100; flits = 0; pidx = 0; sent = 0; stalled = 0; held = '0;
    want = (abort_at >= 0) ? abort_at : int'(len) + 2;
    while (flits < want && cyc < 200) begin
      @(negedge clk);
      ready_i       = toggle ? cyc[0] : 1'b1;
      cmd_valid     = !sent;
      cmd_stream_id = sid;
      cmd_len       = len;
      // Payload is offered even before the command fires; it must not be consumed in IDLE.
      pld_valid     = (pidx <= int'(len));
      pld_data      = (pidx < 16) ? pld_mem[pidx] : '0;
      #1;
      if (stalled) begin
        check_eq("stall_data", data_o, held);
        check_eq("stall_valid", 32'(valid_o), 32'd1);
      end
      stalled = valid_o && !ready_i;
      held    = data_o;
      if (!sent) check_eq("pld_ready_idle", 32'(pld_ready), 32'd0);
      if (valid_o && ready_i) begin
        if (flits == 0) exp = {2'b10, 22'd0, sid};
        else if (flits == int'(len) + 1) exp = {2'b01, pld_mem[flits-1]};
        else exp = {2'b00, pld_mem[flits-1]};
        check_eq($sformatf("flit%0d", flits), data_o, exp);
        if (!toggle) check_eq($sformatf("flit%0d_cycle", flits), cyc, fire_cyc + 1 + flits);
        if (flits == int'(len) + 1) check_eq("cmd_ready_after_tail", 32'(cmd_ready), 32'd1);
        flits++;
      end
      if (cmd_valid && cmd_ready) begin
        sent     = 1'b1;
        fire_cyc = cyc;
      end
      if (pld_valid && pld_ready) pidx++;
      cyc++;
    end
    check_eq("flit_count", flits, want);
    if (abort_at < 0) begin
      check_eq("pld_consumed", pidx, int'(len) + 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      pld_valid = 1'b0;
      ready_i   = 1'b1;
      #1;
      check_eq("idle_valid", 32'(valid_o), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    // Reset with a command already pending.
    cmd_valid     = 1'b1;
    cmd_stream_id = 8'h5;
    pld_valid     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_data", data_o, 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_pld_ready", 32'(pld_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    pld_mem[0] = 30'hA;
    pld_mem[1] = 30'hB;
    pld_mem[2] = 30'hC;
    run_pkt(8'd5, 4'd2, 1'b0, -1);

    pld_mem[0] = 30'h7;
    run_pkt(8'd9, 4'd0, 1'b0, -1);

    pld_mem[0] = 30'hA;
    pld_mem[1] = 30'hB;
    pld_mem[2] = 30'hC;
    run_pkt(8'd5, 4'd2, 1'b1, -1);

    for (int i = 0; i < 16; i++) pld_mem[i] = 30'(i * 32'h111 + 1);
    run_pkt(8'hA3, 4'd15, 1'b0, -1);

    // Abandon a packet after head + one body flit.
    run_pkt(8'd6, 4'd3, 1'b0, 2);
    rstn = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(valid_o), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_pld_ready", 32'(pld_ready), 32'd0);
    cmd_valid = 1'b0;
    pld_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_pkt(8'd6, 4'd1, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
